irq_ctl: RTL and testbench

IRQ_CTL -- requirements
Module: irq_ctl

---
 rtl/mips789_defs.sv | 13 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctl.sv | 128 ++++++++++++
 tb/tb_irq_ctl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips789_defs.sv
// Shared definitions for the interrupt controller: FSM state encodings
// and the default number of request sources.
package mips789_defs;

    localparam int N_SRC_DEFAULT = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_PEND = 2'b01,
        IRQ_CLR  = 2'b10
    } irq_state_t;

endpackage : mips789_defs

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module irq_prio_enc
    import mips789_defs::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int VEC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_valid
);

    // Scan from the highest index down so the lowest set bit is the last writer.
    always_comb begin
        o_vec   = {VEC_W{1'b0}};
        o_valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            o_vec   = i_req[i] ? VEC_W'(i) : o_vec;
            o_valid = o_valid | i_req[i];
        end
    end

endmodule : irq_prio_enc

// File: rtl/irq_ctl.sv
// Interrupt controller: masks and prioritises level requests, presents one
// vector to the CPU, and on acknowledge clears the source's sticky flag.
module irq_ctl
    import mips789_defs::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int VEC_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req_i,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             mask_ld,
    input  logic             gie,
    input  logic             irq_ack_i,
    output logic             irq_o,
    output logic [VEC_W-1:0] irq_vec_o,
    output logic [N_SRC-1:0] clr_o,
    output logic [N_SRC-1:0] isr_o,
    output logic [N_SRC-1:0] mask_o
);

    irq_state_t       r_state;
    logic [N_SRC-1:0] r_mask;
    logic             r_irq;
    logic [VEC_W-1:0] r_vec;
    logic [N_SRC-1:0] r_clr;
    logic [N_SRC-1:0] r_isr;

    logic [N_SRC-1:0] w_pending;
    logic [VEC_W-1:0] w_win;
    logic             w_valid;
    logic [N_SRC-1:0] w_vec_onehot;

    // One-hot decode of a vector index.
    function automatic logic [N_SRC-1:0] onehot(input logic [VEC_W-1:0] vec);
        logic [N_SRC-1:0] one;
        one = {{(N_SRC-1){1'b0}}, 1'b1};
        return one << vec;
    endfunction

    assign w_pending    = req_i & r_mask & {N_SRC{gie}};
    assign w_vec_onehot = onehot(r_vec);

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .i_req   (w_pending),
        .o_vec   (w_win),
        .o_valid (w_valid)
    );

    // Mask register: software may reload it in any controller state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= {N_SRC{1'b0}};
        end else if (mask_ld) begin
            r_mask <= mask_din;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Service FSM with all CPU- and source-facing outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IRQ_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= {VEC_W{1'b0}};
            r_clr   <= {N_SRC{1'b0}};
            r_isr   <= {N_SRC{1'b0}};
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    r_clr <= {N_SRC{1'b0}};
                    r_isr <= {N_SRC{1'b0}};
                    if (w_valid) begin
                        r_state <= IRQ_PEND;
                        r_irq   <= 1'b1;
                        r_vec   <= w_win;
                    end else begin
                        r_irq   <= 1'b0;
                    end
                end
                IRQ_PEND: begin
                    // Acknowledge takes precedence over a simultaneous withdrawal.
                    if (irq_ack_i) begin
                        r_state <= IRQ_CLR;
                        r_irq   <= 1'b0;
                        r_clr   <= w_vec_onehot;
                        r_isr   <= w_vec_onehot;
                    end else if (!w_pending[r_vec]) begin
                        r_state <= IRQ_IDLE;
                        r_irq   <= 1'b0;
                    end else begin
                        r_irq   <= 1'b1;
                    end
                end
                IRQ_CLR: begin
                    // Hold the clear until the source's sticky flag reads back low.
                    if (!req_i[r_vec]) begin
                        r_state <= IRQ_IDLE;
                        r_clr   <= {N_SRC{1'b0}};
                        r_isr   <= {N_SRC{1'b0}};
                    end else begin
                        r_clr   <= w_vec_onehot;
                        r_isr   <= w_vec_onehot;
                    end
                    r_irq <= 1'b0;
                end
                default: begin
                    r_state <= IRQ_IDLE;
                    r_irq   <= 1'b0;
                    r_clr   <= {N_SRC{1'b0}};
                    r_isr   <= {N_SRC{1'b0}};
                end
            endcase
        end
    end

    assign irq_o     = r_irq;
    assign irq_vec_o = r_vec;
    assign clr_o     = r_clr;
    assign isr_o     = r_isr;
    assign mask_o    = r_mask;

endmodule : irq_ctl

// File: tb/tb_irq_ctl.sv
// Directed self-checking bench for irq_ctl (N_SRC=4, VEC_W=2).
module tb_irq_ctl;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] mask_din;
    logic       mask_ld;
    logic       gie;
    logic       irq_ack_i;
    logic       irq_o;
    logic [1:0] irq_vec_o;
    logic [3:0] clr_o;
    logic [3:0] isr_o;
    logic [3:0] mask_o;

    int n_assert = 0;
    int n_fail   = 0;

    irq_ctl #(.N_SRC(4), .VEC_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .mask_din  (mask_din),
        .mask_ld   (mask_ld),
        .gie       (gie),
        .irq_ack_i (irq_ack_i),
        .irq_o     (irq_o),
        .irq_vec_o (irq_vec_o),
        .clr_o     (clr_o),
        .isr_o     (isr_o),
        .mask_o    (mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full registered output set at once.
    task automatic chk_all(input string tag, input logic irq, input logic [1:0] vec,
                           input logic [3:0] clr, input logic [3:0] isr);
        chk({tag, ".irq"}, {31'd0, irq_o}, {31'd0, irq});
        chk({tag, ".vec"}, {30'd0, irq_vec_o}, {30'd0, vec});
        chk({tag, ".clr"}, {28'd0, clr_o}, {28'd0, clr});
        chk({tag, ".isr"}, {28'd0, isr_o}, {28'd0, isr});
    endtask

    initial begin
        rst = 1'b0; req_i = 4'b0000; mask_din = 4'b0000; mask_ld = 1'b0;
        gie = 1'b0; irq_ack_i = 1'b0;
        #3;
        // Asynchronous reset state, before any clock edge.
        chk_all("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("reset.mask", {28'd0, mask_o}, 32'h0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Enable all sources.
        mask_din = 4'b1111; mask_ld = 1'b1; gie = 1'b1;
        tick();
        mask_ld = 1'b0;
        chk("mask_load", {28'd0, mask_o}, 32'hF);

        // Single request on source 2, full service.
        req_i = 4'b0100;
        chk("s2.before_edge", {31'd0, irq_o}, 32'd0);
        tick();
        chk_all("s2.pend", 1'b1, 2'd2, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("s2.clr", 1'b0, 2'd2, 4'b0100, 4'b0100);
        tick();
        chk_all("s2.clr_hold", 1'b0, 2'd2, 4'b0100, 4'b0100);
        req_i = 4'b0000;
        tick();
        chk_all("s2.idle", 1'b0, 2'd2, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("s2.ack_in_idle", 1'b0, 2'd2, 4'b0000, 4'b0000);

        // Two simultaneous requests: 1 first, then 3 after one IDLE cycle.
        req_i = 4'b1010;
        tick();
        chk_all("dual.pend1", 1'b1, 2'd1, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("dual.clr1", 1'b0, 2'd1, 4'b0010, 4'b0010);
        req_i = 4'b1000;
        tick();
        chk_all("dual.idle_gap", 1'b0, 2'd1, 4'b0000, 4'b0000);
        tick();
        chk_all("dual.pend3", 1'b1, 2'd3, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("dual.clr3", 1'b0, 2'd3, 4'b1000, 4'b1000);
        req_i = 4'b0000;
        tick();
        chk_all("dual.done", 1'b0, 2'd3, 4'b0000, 4'b0000);

        // Vector frozen in PEND when a higher-priority request arrives.
        req_i = 4'b0100;
        tick();
        chk_all("freeze.pend", 1'b1, 2'd2, 4'b0000, 4'b0000);
        req_i = 4'b0101;
        tick();
        chk_all("freeze.hold1", 1'b1, 2'd2, 4'b0000, 4'b0000);
        tick();
        chk_all("freeze.hold2", 1'b1, 2'd2, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("freeze.clr", 1'b0, 2'd2, 4'b0100, 4'b0100);
        req_i = 4'b0001;
        tick();
        chk_all("freeze.idle", 1'b0, 2'd2, 4'b0000, 4'b0000);
        tick();
        chk_all("freeze.pend0", 1'b1, 2'd0, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("freeze.clr0", 1'b0, 2'd0, 4'b0001, 4'b0001);
        req_i = 4'b0000;
        tick();
        chk_all("freeze.done", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Withdrawal by masking the latched source, no acknowledge.
        req_i = 4'b0010;
        tick();
        chk_all("wd.pend", 1'b1, 2'd1, 4'b0000, 4'b0000);
        mask_din = 4'b1101; mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        chk("wd.mask", {28'd0, mask_o}, 32'hD);
        tick();
        chk_all("wd.idle", 1'b0, 2'd1, 4'b0000, 4'b0000);
        tick();
        chk_all("wd.stay_idle", 1'b0, 2'd1, 4'b0000, 4'b0000);

        // Acknowledge wins over a simultaneous mask withdrawal.
        mask_din = 4'b1111; mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        tick();
        chk_all("ackwin.pend", 1'b1, 2'd1, 4'b0000, 4'b0000);
        mask_din = 4'b1101; mask_ld = 1'b1; irq_ack_i = 1'b1;
        tick();
        mask_ld = 1'b0; irq_ack_i = 1'b0;
        chk_all("ackwin.clr", 1'b0, 2'd1, 4'b0010, 4'b0010);
        chk("ackwin.mask", {28'd0, mask_o}, 32'hD);
        req_i = 4'b0000;
        tick();
        chk_all("ackwin.done", 1'b0, 2'd1, 4'b0000, 4'b0000);

        // Asynchronous reset in the middle of CLR.
        mask_din = 4'b1111; mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        req_i = 4'b1000;
        tick();
        chk_all("rst.pend", 1'b1, 2'd3, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk_all("rst.clr", 1'b0, 2'd3, 4'b1000, 4'b1000);
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("rst.mask", {28'd0, mask_o}, 32'h0);
        tick();
        rst = 1'b1;
        req_i = 4'b1111;
        tick(); tick();
        chk_all("rst.masked_off", 1'b0, 2'd0, 4'b0000, 4'b0000);
        mask_din = 4'b0001; mask_ld = 1'b1;
        tick();
        mask_ld = 1'b0;
        chk("rst.still_idle", {31'd0, irq_o}, 32'd0);
        tick();
        chk_all("rst.pend0", 1'b1, 2'd0, 4'b0000, 4'b0000);

        // gie=0 withdraws a pending request and blocks new ones.
        gie = 1'b0;
        tick();
        chk_all("gie.withdraw", 1'b0, 2'd0, 4'b0000, 4'b0000);
        tick();
        chk_all("gie.blocked", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // gie=0 does not stop a clear already in progress.
        gie = 1'b1;
        tick();
        chk_all("gie.pend", 1'b1, 2'd0, 4'b0000, 4'b0000);
        irq_ack_i = 1'b1; gie = 1'b0;
        tick();
        irq_ack_i = 1'b0;
        chk_all("gie.clr", 1'b0, 2'd0, 4'b0001, 4'b0001);
        tick();
        chk_all("gie.clr_hold", 1'b0, 2'd0, 4'b0001, 4'b0001);
        req_i = 4'b0000;
        tick();
        chk_all("gie.done", 1'b0, 2'd0, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_irq_ctl
